// File: rtl/hazard_control_mc.sv
// Pipeline hazard controller: load-use stalls, multi-cycle MUL/DIV occupancy,
// memory-wait freeze, exception flush and a saturating stall-cycle counter.
`timescale 1ns/1ps
module hazard_control_mc #(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned MULDIV_LAT = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_mem_ex,
    input  logic [ADDR_W-1:0] target_ex,
    input  logic              re_1_id,
    input  logic              re_2_id,
    input  logic [ADDR_W-1:0] raddr_1_id,
    input  logic [ADDR_W-1:0] raddr_2_id,
    input  logic              muldiv_start_ex,
    input  logic              mem_busy,
    input  logic              flush,
    output logic              hold_if,
    output logic              hold_if_id,
    output logic              hold_id_ex,
    output logic              hold_ex_mem,
    output logic              zeros_if_id,
    output logic              zeros_id_ex,
    output logic              zeros_ex_mem,
    output logic              zeros_mem_wb,
    output logic [CNT_W-1:0]  stall_count,
    output logic              muldiv_busy
);

    localparam int unsigned CW     = $clog2(MULDIV_LAT) + 1;
    localparam bit          USE_MD = (MULDIV_LAT > 1);
    // Guarded so MULDIV_LAT=1 never evaluates a negative reload value.
    localparam logic [CW-1:0] CNT_INIT = USE_MD ? CW'(MULDIV_LAT - 2) : '0;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic md_stall;
    logic ld_window;
    logic load_use;

    assign md_stall  = ((state_q == IDLE) && muldiv_start_ex && USE_MD) ||
                       ((state_q == BUSY) && (cnt_q != '0));
    assign ld_window = (state_q == IDLE) || (cnt_q == '0);
    assign load_use  = read_mem_ex && (target_ex != '0) &&
                       ((re_1_id && (raddr_1_id == target_ex)) ||
                        (re_2_id && (raddr_2_id == target_ex)));

    always_comb begin
        hold_if      = 1'b0;
        hold_if_id   = 1'b0;
        hold_id_ex   = 1'b0;
        hold_ex_mem  = 1'b0;
        zeros_if_id  = 1'b0;
        zeros_id_ex  = 1'b0;
        zeros_ex_mem = 1'b0;
        zeros_mem_wb = 1'b0;
        state_d      = state_q;
        cnt_d        = cnt_q;
        if (rst) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (flush) begin
            zeros_if_id  = 1'b1;
            zeros_id_ex  = 1'b1;
            zeros_ex_mem = 1'b1;
            state_d      = IDLE;
            cnt_d        = '0;
        end else if (mem_busy) begin
            hold_if      = 1'b1;
            hold_if_id   = 1'b1;
            hold_id_ex   = 1'b1;
            hold_ex_mem  = 1'b1;
            zeros_mem_wb = 1'b1;
        end else begin
            if (md_stall) begin
                hold_if      = 1'b1;
                hold_if_id   = 1'b1;
                hold_id_ex   = 1'b1;
                zeros_ex_mem = 1'b1;
            end else if (ld_window && load_use) begin
                hold_if     = 1'b1;
                hold_if_id  = 1'b1;
                zeros_id_ex = 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (muldiv_start_ex && USE_MD) begin
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
                default: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (hold_if && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign muldiv_busy = (state_q == BUSY);

endmodule
